display_sequencer: RTL and testbench
====================================

// Module: display_sequencer
// PURPOSE
//  Display scheduler between the fitbit stats datapath and the sevenseg driver.
//  Selects one of four metrics, auto-rotating or switch-selected.
//  Converts it to 4 BCD digits with a multi-cycle sequential converter.
//  Supplies digits, decimal point and blanking to sevenseg.
// PARAMETERS
//  DWELL_TICKS    200_000_000  clocks each metric is shown in auto mode (2 s @100 MHz)
//  REFRESH_TICKS  10_000_000   clocks between re-conversions of the current metric (100 ms)
//  SAT_VALUE      9999         largest displayable value; larger inputs clamp to it
// PORTS
//  clk                     in   1   system clock
//  reset                   in   1   synchronous, active-high reset
//  auto_mode               in   1   1 = rotate metrics every DWELL_TICKS; 0 = use mode_sel
//  mode_sel                in   2   manual metric select (encodings in package)
//  step_count              in   32  metric 0
//  distance_covered        in   16  metric 1, fixed point, 1 fractional digit
//  initial_activity_count  in   4   metric 2, zero-extended
//  high_activity_time      in   16  metric 3
//  output_mode             out  2   metric currently displayed
//  disp_bcd                out  16  {d3,d2,d1,d0} BCD, d0 = rightmost digit
//  disp_dp                 out  4   one-hot decimal point per digit
//  disp_blank              out  4   1 = digit is a leading zero and must be blanked
//  disp_valid              out  1   one-cycle pulse when disp_bcd/dp/blank update
//  sat                     out  1   committed value was clamped to SAT_VALUE
// BEHAVIOUR
//  Reset: every output is 0, dwell and refresh counters are 0, FSM is IDLE.
//  Metric select:
//   - auto_mode=1: output_mode increments mod 4 when dwell_cnt reaches DWELL_TICKS-1.
//   - auto_mode=0: output_mode <= mode_sel each cycle, and dwell_cnt is held at 0.
//   - Leaving manual for auto keeps the current output_mode and restarts the dwell.
//  Refresh trigger (trig), any of:
//   - refresh_cnt reaches REFRESH_TICKS-1; the counter wraps to 0.
//   - output_mode changes.
//   - first cycle after reset.
//  FSM:
//   - IDLE -trig-> LOAD: sample the selected metric, clamp to SAT_VALUE, latch sat_next.
//   - LOAD -> CONV: 14 shift/add-3 iterations, one per clock.
//   - CONV -> COMMIT after iteration 14. COMMIT -> IDLE.
//   - COMMIT writes disp_bcd, disp_dp, disp_blank and sat, and pulses disp_valid.
//   - Latency from trig to disp_valid: 16 clocks (1 LOAD + 14 CONV + 1 COMMIT).
//  A new trig while in LOAD or CONV aborts the conversion and restarts LOAD.
//   - The old digits stay on the display; no disp_valid is issued for the aborted run.
//  A trig during COMMIT is registered and serviced in the next cycle (IDLE->LOAD).
//  Clamp: compare at full input width, before truncation to 14 bits.
//   - step_count=32'h0001_0000 displays 9999 with sat=1.
//  disp_dp: 4'b0010 for metric 1 (shown as ddd.d); 4'b0000 for all other metrics.
//  disp_blank: digit k is blanked if it and all digits to its left are 0.
//   - Digit 0 is never blanked.
//   - For metric 1, digit 1 is never blanked, so 0.5 shows as " 0.5".
//  Inputs are sampled only in LOAD; changes during CONV do not corrupt the result.
//  Reset in any state returns to IDLE, clears outputs in the same edge, and forces trig.
// STRUCTURE
//  Package fitbit_pkg:
//   - MODE_STEPS=0, MODE_DIST=1, MODE_INIT_ACT=2, MODE_HIGH_TIME=3.
//   - DISP_SAT=9999 and the FSM state encoding (IDLE/LOAD/CONV/COMMIT).
//  Sub-module bin2bcd_seq: iterative double-dabble, 14-bit in, 16-bit BCD out.
//   - Ports: start (1-cycle), din, busy, done (1-cycle), bcd.
//   - A start while busy restarts the conversion.
//  Top level keeps the counters, metric mux/clamp, FSM, and dp/blank logic.
// TESTING  (sim parameters DWELL_TICKS=20, REFRESH_TICKS=8)
//  1. Reset, auto_mode=0, mode_sel=0, step_count=1234 -> disp_valid 16 clks after
//     reset release; disp_bcd=16'h1234, blank=0000, dp=0000, sat=0.
//  2. mode_sel=1, distance_covered=5 -> disp_bcd=16'h0005, dp=0010, blank=1100.
//  3. step_count=70000 -> disp_bcd=16'h9999, sat=1; then step_count=42 -> next refresh
//     gives 16'h0042, blank=1100, sat=0.
//  4. auto_mode=1 -> output_mode 0,1,2,3,0 every 20 clks; one disp_valid per change.
//     initial_activity_count=4'hF shows 16'h0015.
//  5. Change mode_sel at CONV iteration 7 -> no disp_valid for the old metric; the new
//     value commits 16 clks after the change; disp_bcd holds the old digits until then.
//  6. Assert reset during CONV -> all outputs 0 on the next edge; after release a fresh
//     conversion commits 16 clks later.

Source files
------------

// File: rtl/fitbit_pkg.sv
// Shared encodings and helpers for the fitbit display path.
package fitbit_pkg;

    // Metric encodings used on mode_sel and output_mode.
    typedef enum logic [1:0] {
        MODE_STEPS     = 2'd0,
        MODE_DIST      = 2'd1,
        MODE_INIT_ACT  = 2'd2,
        MODE_HIGH_TIME = 2'd3
    } mode_e;

    // Display sequencer FSM states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CONV   = 2'd2,
        COMMIT = 2'd3
    } state_e;

    // Largest value four digits can show. Kept at 32 bits so the clamp
    // compares against the full input width.
    localparam logic [31:0] DISP_SAT = 32'd9999;

    localparam int BIN_W      = 14;     // enough for 0..9999
    localparam int BCD_W      = 16;     // four BCD digits
    localparam int CONV_ITERS = BIN_W;  // one shift per input bit

    // Double-dabble digit correction: digits of 5 or more get 3 added
    // before the shift so they carry correctly into the next digit.
    function automatic logic [3:0] add3(input logic [3:0] d);
        return (d >= 4'd5) ? d + 4'd3 : d;
    endfunction

    // Leading-zero blanking. Digit 0 is always lit; keep_d1 also keeps
    // digit 1 lit so fixed-point values show as "0.5" rather than ".5".
    function automatic logic [3:0] blank_mask(input logic [15:0] bcd,
                                              input logic        keep_d1);
        logic [3:0] m;
        m[3] = (bcd[15:12] == 4'd0);
        m[2] = m[3] && (bcd[11:8] == 4'd0);
        m[1] = m[2] && (bcd[7:4] == 4'd0) && !keep_d1;
        m[0] = 1'b0;
        return m;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Iterative double-dabble converter: 14-bit binary to four BCD digits,
// one shift/add-3 step per clock. A start while busy restarts.
module bin2bcd_seq
    import fitbit_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [BIN_W-1:0] din,
    output logic             busy,
    output logic             done,
    output logic [BCD_W-1:0] bcd
);

    localparam logic [3:0] LAST_ITER = 4'(CONV_ITERS - 1);

    logic [BCD_W+BIN_W-1:0] shift_q, shift_d, stepped;
    logic [3:0]             iter_q, iter_d;
    logic                   busy_q, busy_d;

    // One double-dabble step on the current shift register, plus next-state.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it
        // unassigned; an unassigned path in combinational logic infers a latch.
        stepped = shift_q;
        shift_d = shift_q;
        iter_d  = iter_q;
        busy_d  = busy_q;

        for (int k = 0; k < BCD_W / 4; k++) begin
            stepped[BIN_W + 4*k +: 4] = add3(shift_q[BIN_W + 4*k +: 4]);
        end
        stepped = stepped << 1;

        if (start) begin
            shift_d = {{BCD_W{1'b0}}, din};
            iter_d  = 4'd0;
            busy_d  = 1'b1;
        end else if (busy_q) begin
            shift_d = stepped;
            iter_d  = iter_q + 4'd1;
            if (iter_q == LAST_ITER) begin
                busy_d = 1'b0;
            end
        end
    end

    // The final step's result is presented combinationally so the caller
    // can capture it on the same edge that completes the conversion.
    assign busy = busy_q;
    assign done = busy_q && !start && (iter_q == LAST_ITER);
    assign bcd  = stepped[BCD_W+BIN_W-1:BIN_W];

    // Control flops reset; the shift register is reloaded on every start.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values
        // regardless of statement order.
        if (reset) begin
            busy_q <= 1'b0;
            iter_q <= 4'd0;
        end else begin
            busy_q <= busy_d;
            iter_q <= iter_d;
        end
        // NOTE: shift_q is pure datapath and is left unreset; it is only
        // observed through done, which busy_q gates after reset.
        shift_q <= shift_d;
    end

endmodule

// File: rtl/display_sequencer.sv
// Display scheduler: picks a metric, clamps it, converts it to BCD and
// hands digits, decimal point and blanking to the seven-segment driver.
module display_sequencer
    import fitbit_pkg::*;
#(
    parameter int unsigned DWELL_TICKS   = 200_000_000,
    parameter int unsigned REFRESH_TICKS = 10_000_000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        auto_mode,
    input  logic [1:0]  mode_sel,
    input  logic [31:0] step_count,
    input  logic [15:0] distance_covered,
    input  logic [3:0]  initial_activity_count,
    input  logic [15:0] high_activity_time,
    output logic [1:0]  output_mode,
    output logic [15:0] disp_bcd,
    output logic [3:0]  disp_dp,
    output logic [3:0]  disp_blank,
    output logic        disp_valid,
    output logic        sat
);

    localparam int DWELL_W   = (DWELL_TICKS   > 1) ? $clog2(DWELL_TICKS)   : 1;
    localparam int REFRESH_W = (REFRESH_TICKS > 1) ? $clog2(REFRESH_TICKS) : 1;
    localparam logic [DWELL_W-1:0]   DWELL_LAST   = DWELL_W'(DWELL_TICKS - 1);
    localparam logic [REFRESH_W-1:0] REFRESH_LAST = REFRESH_W'(REFRESH_TICKS - 1);

    state_e                state_q, state_d;
    logic [1:0]            output_mode_q, output_mode_d;
    logic [DWELL_W-1:0]    dwell_q, dwell_d;
    logic [REFRESH_W-1:0]  refresh_q, refresh_d;
    logic                  first_q, first_d;
    logic                  pend_q, pend_d;
    logic [1:0]            conv_mode_q, conv_mode_d;
    logic                  sat_next_q, sat_next_d;
    logic [15:0]           disp_bcd_q, disp_bcd_d;
    logic [3:0]            disp_dp_q, disp_dp_d;
    logic [3:0]            disp_blank_q, disp_blank_d;
    logic                  disp_valid_q, disp_valid_d;
    logic                  sat_q, sat_d;

    logic [31:0]           metric_raw;
    logic                  over_sat;
    logic [BIN_W-1:0]      conv_din;
    logic                  conv_start, conv_busy, conv_done;
    logic [BCD_W-1:0]      conv_bcd;
    logic                  refresh_hit, trig;

    // Metric mux, zero-extended to 32 bits, then clamped at full width.
    always_comb begin
        metric_raw = 32'd0;
        case (output_mode_q)
            MODE_STEPS:     metric_raw = step_count;
            MODE_DIST:      metric_raw = {16'd0, distance_covered};
            MODE_INIT_ACT:  metric_raw = {28'd0, initial_activity_count};
            MODE_HIGH_TIME: metric_raw = {16'd0, high_activity_time};
            default:        metric_raw = 32'd0;
        endcase
        over_sat = (metric_raw > DISP_SAT);
        conv_din = over_sat ? DISP_SAT[BIN_W-1:0] : metric_raw[BIN_W-1:0];
    end

    bin2bcd_seq u_bin2bcd (
        .clk   (clk),
        .reset (reset),
        .start (conv_start),
        .din   (conv_din),
        .busy  (conv_busy),
        .done  (conv_done),
        .bcd   (conv_bcd)
    );

    // Metric rotation, refresh timing, trigger and FSM next-state.
    always_comb begin
        state_d       = state_q;
        output_mode_d = output_mode_q;
        dwell_d       = dwell_q;
        refresh_d     = refresh_q;
        first_d       = 1'b0;
        pend_d        = pend_q;
        conv_mode_d   = conv_mode_q;
        sat_next_d    = sat_next_q;
        disp_bcd_d    = disp_bcd_q;
        disp_dp_d     = disp_dp_q;
        disp_blank_d  = disp_blank_q;
        disp_valid_d  = 1'b0;
        sat_d         = sat_q;
        conv_start    = 1'b0;
        refresh_hit   = 1'b0;

        if (auto_mode) begin
            if (dwell_q == DWELL_LAST) begin
                dwell_d       = '0;
                output_mode_d = output_mode_q + 2'd1;
            end else begin
                dwell_d = dwell_q + 1'b1;
            end
        end else begin
            dwell_d       = '0;
            output_mode_d = mode_sel;
        end

        // The refresh interval is measured across idle time only, so a
        // refresh can never abort the conversion it started.
        if (state_q == IDLE) begin
            if (refresh_q == REFRESH_LAST) begin
                refresh_d   = '0;
                refresh_hit = 1'b1;
            end else begin
                refresh_d = refresh_q + 1'b1;
            end
        end else begin
            refresh_d = '0;
        end

        trig = refresh_hit || (output_mode_d != output_mode_q) || first_q;

        case (state_q)
            IDLE: begin
                if (trig || pend_q) begin
                    state_d = LOAD;
                    pend_d  = 1'b0;
                end
            end
            LOAD: begin
                conv_start  = 1'b1;
                conv_mode_d = output_mode_q;
                sat_next_d  = over_sat;
                state_d     = trig ? LOAD : CONV;
            end
            CONV: begin
                if (trig) begin
                    state_d = LOAD;
                end else if (conv_done) begin
                    state_d      = COMMIT;
                    disp_bcd_d   = conv_bcd;
                    disp_dp_d    = (conv_mode_q == MODE_DIST) ? 4'b0010 : 4'b0000;
                    disp_blank_d = blank_mask(conv_bcd, conv_mode_q == MODE_DIST);
                    sat_d        = sat_next_q;
                    disp_valid_d = 1'b1;
                end else if (!conv_busy) begin
                    state_d = IDLE;
                end
            end
            COMMIT: begin
                state_d = IDLE;
                if (trig) begin
                    pend_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // All sequencer state; reset clears outputs and arms the first trigger.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            output_mode_q <= 2'd0;
            dwell_q       <= '0;
            refresh_q     <= '0;
            first_q       <= 1'b1;
            pend_q        <= 1'b0;
            conv_mode_q   <= 2'd0;
            sat_next_q    <= 1'b0;
            disp_bcd_q    <= 16'd0;
            disp_dp_q     <= 4'd0;
            disp_blank_q  <= 4'd0;
            disp_valid_q  <= 1'b0;
            sat_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            output_mode_q <= output_mode_d;
            dwell_q       <= dwell_d;
            refresh_q     <= refresh_d;
            first_q       <= first_d;
            pend_q        <= pend_d;
            conv_mode_q   <= conv_mode_d;
            sat_next_q    <= sat_next_d;
            disp_bcd_q    <= disp_bcd_d;
            disp_dp_q     <= disp_dp_d;
            disp_blank_q  <= disp_blank_d;
            disp_valid_q  <= disp_valid_d;
            sat_q         <= sat_d;
        end
    end

    assign output_mode = output_mode_q;
    assign disp_bcd    = disp_bcd_q;
    assign disp_dp     = disp_dp_q;
    assign disp_blank  = disp_blank_q;
    assign disp_valid  = disp_valid_q;
    assign sat         = sat_q;

endmodule

// File: tb/tb_display_sequencer.sv
// Directed self-checking bench for display_sequencer with short dwell and
// refresh intervals.
module tb_display_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        auto_mode;
    logic [1:0]  mode_sel;
    logic [31:0] step_count;
    logic [15:0] distance_covered;
    logic [3:0]  initial_activity_count;
    logic [15:0] high_activity_time;
    logic [1:0]  output_mode;
    logic [15:0] disp_bcd;
    logic [3:0]  disp_dp;
    logic [3:0]  disp_blank;
    logic        disp_valid;
    logic        sat;

    int n_checks = 0;
    int n_pass   = 0;

    display_sequencer #(
        .DWELL_TICKS   (20),
        .REFRESH_TICKS (8)
    ) dut (
        .clk                    (clk),
        .reset                  (reset),
        .auto_mode              (auto_mode),
        .mode_sel               (mode_sel),
        .step_count             (step_count),
        .distance_covered       (distance_covered),
        .initial_activity_count (initial_activity_count),
        .high_activity_time     (high_activity_time),
        .output_mode            (output_mode),
        .disp_bcd               (disp_bcd),
        .disp_dp                (disp_dp),
        .disp_blank             (disp_blank),
        .disp_valid             (disp_valid),
        .sat                    (sat)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Waits (on falling edges) for disp_valid; exp_lat < 0 skips the latency check.
    task automatic wait_valid(input string tag, input int exp_lat);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!disp_valid && n < 100);
        check({tag, "_seen"}, 32'(disp_valid), 32'd1);
        if (exp_lat >= 0) begin
            check({tag, "_lat"}, 32'(n), 32'(exp_lat));
        end
    endtask

    task automatic expect_disp(input string tag, input logic [15:0] bcd, input logic [3:0] dp,
                               input logic [3:0] blank, input logic s, input logic [1:0] mode);
        check({tag, "_bcd"},   32'(disp_bcd),    32'(bcd));
        check({tag, "_dp"},    32'(disp_dp),     32'(dp));
        check({tag, "_blank"}, 32'(disp_blank),  32'(blank));
        check({tag, "_sat"},   32'(sat),         32'(s));
        check({tag, "_mode"},  32'(output_mode), 32'(mode));
    endtask

    initial begin
        int v;
        int held;

        reset                  = 1'b1;
        auto_mode              = 1'b0;
        mode_sel               = 2'd0;
        step_count             = 32'd1234;
        distance_covered       = 16'd5;
        initial_activity_count = 4'hF;
        high_activity_time     = 16'd777;

        // 1. reset state, then first conversion 16 clocks after release
        repeat (3) @(negedge clk);
        expect_disp("rst", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        check("rst_valid", 32'(disp_valid), 32'd0);
        reset = 1'b0;
        wait_valid("first", 16);
        expect_disp("first", 16'h1234, 4'b0000, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        check("valid_pulse", 32'(disp_valid), 32'd0);

        // 2. distance metric: decimal point, digit 1 kept lit
        mode_sel = 2'd1;
        wait_valid("dist", 16);
        expect_disp("dist", 16'h0005, 4'b0010, 4'b1100, 1'b0, 2'd1);

        // 3. clamp at full width, then refresh back below the limit
        @(negedge clk);
        mode_sel   = 2'd0;
        step_count = 32'd70000;
        wait_valid("sat70k", 16);
        expect_disp("sat70k", 16'h9999, 4'b0000, 4'b0000, 1'b1, 2'd0);
        @(negedge clk);
        step_count = 32'h0001_0000;
        wait_valid("sat64k", -1);
        expect_disp("sat64k", 16'h9999, 4'b0000, 4'b0000, 1'b1, 2'd0);
        @(negedge clk);
        step_count = 32'd9999;
        wait_valid("exact", -1);
        expect_disp("exact", 16'h9999, 4'b0000, 4'b0000, 1'b0, 2'd0);
        @(negedge clk);
        step_count = 32'd42;
        wait_valid("s42", -1);
        expect_disp("s42", 16'h0042, 4'b0000, 4'b1100, 1'b0, 2'd0);

        // 4. auto rotation: one commit per metric change, 20 clocks apart
        @(negedge clk);
        auto_mode = 1'b1;
        wait_valid("auto1", 35);
        expect_disp("auto1", 16'h0005, 4'b0010, 4'b1100, 1'b0, 2'd1);
        wait_valid("auto2", 20);
        expect_disp("auto2", 16'h0015, 4'b0000, 4'b1100, 1'b0, 2'd2);
        wait_valid("auto3", 20);
        expect_disp("auto3", 16'h0777, 4'b0000, 4'b1000, 1'b0, 2'd3);
        wait_valid("auto0", 20);
        expect_disp("auto0", 16'h0042, 4'b0000, 4'b1100, 1'b0, 2'd0);

        // 5. metric change in the middle of a conversion aborts it
        auto_mode = 1'b0;
        mode_sel  = 2'd0;
        @(negedge clk);
        mode_sel = 2'd3;
        v = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (disp_valid) v++;
        end
        check("abort_pre_valid", 32'(v), 32'd0);
        mode_sel = 2'd2;
        v    = 0;
        held = 1;
        for (int i = 0; i < 15; i++) begin
            @(negedge clk);
            if (disp_valid) v++;
            if (disp_bcd !== 16'h0042) held = 0;
        end
        check("abort_no_valid", 32'(v), 32'd0);
        check("abort_digits_held", 32'(held), 32'd1);
        @(negedge clk);
        check("abort_commit", 32'(disp_valid), 32'd1);
        expect_disp("abort", 16'h0015, 4'b0000, 4'b1100, 1'b0, 2'd2);

        // 6. reset during a conversion clears outputs, then restarts
        @(negedge clk);
        mode_sel = 2'd3;
        repeat (5) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        expect_disp("midrst", 16'h0000, 4'b0000, 4'b0000, 1'b0, 2'd0);
        check("midrst_valid", 32'(disp_valid), 32'd0);
        reset = 1'b0;
        wait_valid("postrst", 16);
        expect_disp("postrst", 16'h0777, 4'b0000, 4'b1000, 1'b0, 2'd3);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
